seq_gen_tx: RTL and testbench

Serial frame transmitter that drives a single-bit stream, one bit per clock, for the "101" sequence detectors. It accepts a parallel data word over a valid/ready handshake and emits a frame: the sync pattern 1-0-1, then the data word MSB-first, then a gap of idle zeros. It sits upstream of a detector and serves as the stimulus and traffic source for the serial-stream labs.

---
 rtl/seq_gen_tx_pkg.sv | 31 +++
 rtl/seq_gen_tx_piso_shreg.sv | 28 ++
 rtl/seq_gen_tx.sv | 108 ++++++++++
 tb/tb_seq_gen_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_gen_tx_pkg.sv
// Shared constants and state encoding for the serial "101" frame transmitter
// and the detector lab that consumes its stream.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } seq_state_e;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int unsigned SYNC_LEN = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // ord counts sync bits in transmit order (0 = first); pattern is sent MSB-first
  function automatic logic sync_bit(input logic [1:0] ord);
    logic [1:0] idx;
    idx = 2'(SYNC_LEN - 1) - ord;
    return (ord < 2'(SYNC_LEN)) ? SYNC_PATTERN[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/seq_gen_tx_piso_shreg.sv
// Parallel-in serial-out shift register holding the data word of the frame
// in flight; msb is the next data bit to go on the line.
module piso_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= d;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/seq_gen_tx.sv
// Serial frame transmitter: sync 1-0-1, DATA_W data bits MSB-first, then
// GAP_CYCLES idle zeros, one bit per clock, word accepted over valid/ready.
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              seq_out,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state_out
);

  localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic             msb;

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    state_out = state;
    load      = in_valid && (state == IDLE);
    // msb is consumed on the last sync edge and on every data edge but the last
    shift     = ((state == SYNC) && (cnt == SYNC_LAST)) ||
                ((state == DATA) && (cnt != DATA_LAST));
  end

  piso_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .d     (in_data),
    .msb   (msb)
  );

  // seq_out is computed for the state being entered, so the first sync bit
  // appears in the cycle right after the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      seq_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          seq_out <= 1'b0;
          if (in_valid) begin
            state   <= SYNC;
            seq_out <= sync_bit(2'd0);
          end
        end
        SYNC: begin
          if (cnt == SYNC_LAST) begin
            state   <= DATA;
            cnt     <= '0;
            seq_out <= msb;
          end else begin
            cnt     <= cnt + 1'b1;
            seq_out <= sync_bit(cnt[1:0] + 2'd1);
          end
        end
        DATA: begin
          if (cnt == DATA_LAST) begin
            state      <= GAP;
            cnt        <= '0;
            seq_out    <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            seq_out <= msb;
          end
        end
        GAP: begin
          seq_out <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          seq_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx (DATA_W=8, GAP_CYCLES=2) with a behavioural
// non-overlapping "101" detector fed from the serial line.
module tb_seq_gen_tx;

  localparam int W    = 8;
  localparam int G    = 2;
  localparam int FLEN = 3 + W + G;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] in_data  = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       seq_out;
  logic       busy;
  logic       frame_done;
  logic [1:0] state_out;

  int errors = 0;
  int checks = 0;
  int det_st;
  int first_hit;

  always #5 clk = ~clk;

  seq_gen_tx #(.DATA_W(W), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .seq_out    (seq_out),
    .busy       (busy),
    .frame_done (frame_done),
    .state_out  (state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Non-overlapping 101 detector: 0 = nothing, 1 = saw 1, 2 = saw 10
  task automatic det_feed(input logic b, input int k);
    logic hit;
    hit = 1'b0;
    case (det_st)
      0: det_st = b ? 1 : 0;
      1: det_st = b ? 1 : 2;
      default: begin
        hit    = b;
        det_st = 0;
      end
    endcase
    if (hit && first_hit < 0) first_hit = k;
  endtask

  task automatic start(input logic [7:0] d, input string tag);
    @(negedge clk);
    check({tag, "/ready_pre"}, in_ready, 1'b1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Call right after the handshake edge; checks cycles 1..FLEN+1.
  task automatic capture(input logic [7:0] d, input string tag, input logic hold,
                         input logic [7:0] nd, input int pulse);
    logic [FLEN-1:0] fr;
    logic            exp_bit;
    logic [1:0]      exp_st;
    fr        = {3'b101, d, {G{1'b0}}};
    det_st    = 0;
    first_hit = -1;
    for (int k = 1; k <= FLEN + 1; k++) begin
      @(negedge clk);
      exp_bit = (k <= FLEN) ? fr[FLEN-k] : 1'b0;
      exp_st  = (k <= 3) ? 2'd1 : (k <= 3 + W) ? 2'd2 : (k <= FLEN) ? 2'd3 : 2'd0;
      check($sformatf("%s/seq@%0d", tag, k), seq_out, exp_bit);
      check($sformatf("%s/done@%0d", tag, k), frame_done, (k == 4 + W));
      check($sformatf("%s/ready@%0d", tag, k), in_ready, (k > FLEN));
      check($sformatf("%s/busy@%0d", tag, k), busy, (k <= FLEN));
      check($sformatf("%s/state@%0d", tag, k), state_out, exp_st);
      det_feed(seq_out, k);
      if (k == 1) begin
        in_valid = hold;
        in_data  = nd;
      end
      if (pulse != 0 && k == pulse) begin
        in_valid = 1'b1;
        in_data  = ~nd;
      end
      if (pulse != 0 && k == pulse + 1) in_valid = 1'b0;
    end
    check({tag, "/det_first"}, first_hit, 3);
  endtask

  initial begin
    logic [7:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/seq", seq_out, 1'b0);
    check("rst/done", frame_done, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/ready", in_ready, 1'b1);
    check("rst/state", state_out, 2'd0);
    rst_n = 1'b1;

    // Idle, no in_valid
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle/seq@%0d", i), seq_out, 1'b0);
      check($sformatf("idle/ready@%0d", i), in_ready, 1'b1);
      check($sformatf("idle/state@%0d", i), state_out, 2'd0);
    end

    // Single frame 8'hA5: 1,0,1,1,0,1,0,0,1,0,1,0,0
    start(8'hA5, "a5");
    capture(8'hA5, "a5", 1'b0, 8'hA5, 0);

    // Back-to-back with in_valid held: second handshake on the IDLE-cycle edge
    start(8'hFF, "ff");
    capture(8'hFF, "ff", 1'b1, 8'h00, 0);
    capture(8'h00, "b2b00", 1'b0, 8'h00, 0);

    // in_valid pulse while busy, in_data changed mid-frame
    start(8'h3C, "pulse");
    capture(8'h3C, "pulse", 1'b0, 8'hC3, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("pulse/nostart_state@%0d", i), state_out, 2'd0);
      check($sformatf("pulse/nostart_seq@%0d", i), seq_out, 1'b0);
    end

    // Asynchronous reset mid-DATA (cycle 7)
    start(8'hC3, "arst");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("arst/state_c6", state_out, 2'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst/seq", seq_out, 1'b0);
    check("arst/state", state_out, 2'd0);
    check("arst/done", frame_done, 1'b0);
    check("arst/busy", busy, 1'b0);
    check("arst/ready", in_ready, 1'b1);
    @(negedge clk);
    check("arst/held_state", state_out, 2'd0);
    rst_n = 1'b1;
    start(8'h5A, "post_rst");
    capture(8'h5A, "post_rst", 1'b0, 8'h5A, 0);

    // Loopback into the detector, random words
    for (int n = 0; n < 20; n++) begin
      w = 8'($urandom_range(0, 255));
      start(w, $sformatf("rnd%0d", n));
      capture(w, $sformatf("rnd%0d", n), 1'b0, w, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
